// File: rtl/network_interface.sv
// Tile network interface: packs core TX into NoC packets, unpacks router ejections to the core.
// Latency 1 cycle each way; TX register holds until i_routerReady, RX register holds until i_rxReady.
package pa_noc;
  localparam int PACKET_WIDTH = 16;
endpackage

module network_interface #(
  parameter  int GRID_WIDTH    = 4,
  parameter  int NI_ROW        = 0,
  parameter  int NI_COL        = 0,
  parameter  int CNT_WIDTH     = 16,
  localparam int COORD_WIDTH   = $clog2(GRID_WIDTH),
  localparam int PACKET_WIDTH  = pa_noc::PACKET_WIDTH,
  localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 4*COORD_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [PAYLOAD_WIDTH-1:0] i_txPayload,
  input  logic [COORD_WIDTH-1:0]   i_txDstRow,
  input  logic [COORD_WIDTH-1:0]   i_txDstCol,
  input  logic                     i_txValid,
  output logic                     o_txReady,
  output logic [PACKET_WIDTH-1:0]  o_router,
  output logic                     o_routerValid,
  input  logic                     i_routerReady,
  input  logic [PACKET_WIDTH-1:0]  i_router,
  input  logic                     i_routerValid,
  output logic                     o_routerReady,
  output logic [PAYLOAD_WIDTH-1:0] o_rxPayload,
  output logic [COORD_WIDTH-1:0]   o_rxSrcRow,
  output logic [COORD_WIDTH-1:0]   o_rxSrcCol,
  output logic                     o_rxValid,
  input  logic                     i_rxReady,
  output logic [CNT_WIDTH-1:0]     o_txCount,
  output logic [CNT_WIDTH-1:0]     o_rxCount,
  output logic                     o_misroute
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [COORD_WIDTH-1:0] MY_ROW = COORD_WIDTH'(NI_ROW);
  localparam logic [COORD_WIDTH-1:0] MY_COL = COORD_WIDTH'(NI_COL);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [0:0]               state_q, state_d;
  logic [PACKET_WIDTH-1:0]  router_q, router_d;
  logic [PAYLOAD_WIDTH-1:0] rx_payload_q, rx_payload_d;
  logic [COORD_WIDTH-1:0]   rx_src_row_q, rx_src_row_d;
  logic [COORD_WIDTH-1:0]   rx_src_col_q, rx_src_col_d;
  logic                     rx_vld_q, rx_vld_d;
  logic [CNT_WIDTH-1:0]     tx_cnt_q, tx_cnt_d;
  logic [CNT_WIDTH-1:0]     rx_cnt_q, rx_cnt_d;
  logic                     misroute_q, misroute_d;

  logic [PACKET_WIDTH-1:0]  tx_pkt;
  logic                     tx_xfer;
  logic                     rx_accept;
  logic                     rx_match;
  logic                     rx_consume;

  assign tx_pkt  = {i_txPayload, MY_ROW, MY_COL, i_txDstRow, i_txDstCol};
  assign tx_xfer = (state_q == ST_FULL) && i_routerReady;

  assign o_txReady     = (state_q == ST_EMPTY) || i_routerReady;
  assign o_routerValid = (state_q == ST_FULL);
  assign o_router      = router_q;

  // Single-entry output register; a transfer and a new load may share a cycle.
  always_comb begin
    state_d  = state_q;
    router_d = router_q;
    case (state_q)
      ST_EMPTY: begin
        if (i_txValid) begin
          router_d = tx_pkt;
          state_d  = ST_FULL;
        end
      end
      default: begin
        if (tx_xfer) begin
          if (i_txValid) begin
            router_d = tx_pkt;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
    endcase
  end

  assign o_routerReady = !rx_vld_q || i_rxReady;
  assign rx_accept     = i_routerValid && o_routerReady;
  assign rx_match      = (i_router[2*COORD_WIDTH-1:COORD_WIDTH] == MY_ROW) &&
                         (i_router[COORD_WIDTH-1:0] == MY_COL);
  assign rx_consume    = rx_vld_q && i_rxReady;

  always_comb begin
    rx_payload_d = rx_payload_q;
    rx_src_row_d = rx_src_row_q;
    rx_src_col_d = rx_src_col_q;
    rx_vld_d     = rx_vld_q;
    misroute_d   = misroute_q;
    if (rx_accept && rx_match) begin
      rx_payload_d = i_router[PACKET_WIDTH-1:4*COORD_WIDTH];
      rx_src_row_d = i_router[4*COORD_WIDTH-1:3*COORD_WIDTH];
      rx_src_col_d = i_router[3*COORD_WIDTH-1:2*COORD_WIDTH];
      rx_vld_d     = 1'b1;
    end else if (rx_consume) begin
      rx_vld_d = 1'b0;
    end
    // Misaddressed packets are still popped from the router so they cannot block it.
    if (rx_accept && !rx_match) begin
      misroute_d = 1'b1;
    end
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_xfer && (tx_cnt_q != CNT_MAX)) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
    if (rx_consume && (rx_cnt_q != CNT_MAX)) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= ST_EMPTY;
      router_q     <= '0;
      rx_payload_q <= '0;
      rx_src_row_q <= '0;
      rx_src_col_q <= '0;
      rx_vld_q     <= 1'b0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      misroute_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      router_q     <= router_d;
      rx_payload_q <= rx_payload_d;
      rx_src_row_q <= rx_src_row_d;
      rx_src_col_q <= rx_src_col_d;
      rx_vld_q     <= rx_vld_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      misroute_q   <= misroute_d;
    end
  end

  assign o_rxPayload = rx_payload_q;
  assign o_rxSrcRow  = rx_src_row_q;
  assign o_rxSrcCol  = rx_src_col_q;
  assign o_rxValid   = rx_vld_q;
  assign o_txCount   = tx_cnt_q;
  assign o_rxCount   = rx_cnt_q;
  assign o_misroute  = misroute_q;

endmodule

// File: tb/tb_network_interface.sv
// Bench for network_interface at tile (1,2) of a 4x4 mesh; a second instance with 2-bit counters checks saturation.
module tb_network_interface;
  localparam int ROW = 1;
  localparam int COL = 2;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic [7:0]  tx_payload;
  logic [1:0]  tx_dst_row, tx_dst_col;
  logic        tx_valid;
  logic        router_ready_in;
  logic [15:0] router_in;
  logic        router_valid_in;
  logic        rx_ready;

  logic        tx_ready, router_valid, router_ready, rx_valid, misroute;
  logic [15:0] router_out;
  logic [7:0]  rx_payload;
  logic [1:0]  rx_src_row, rx_src_col;
  logic [15:0] tx_count, rx_count;

  logic        tx_ready2, router_valid2, router_ready2, rx_valid2, misroute2;
  logic [15:0] router_out2;
  logic [7:0]  rx_payload2;
  logic [1:0]  rx_src_row2, rx_src_col2;
  logic [1:0]  tx_count2, rx_count2;

  int tests = 0;
  int fails = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  int          m_tx_cnt;
  int          m_rx_cnt;
  bit          m_misroute;

  always #5 i_clk = ~i_clk;

  network_interface #(.GRID_WIDTH(4), .NI_ROW(ROW), .NI_COL(COL), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_txPayload(tx_payload), .i_txDstRow(tx_dst_row), .i_txDstCol(tx_dst_col),
    .i_txValid(tx_valid), .o_txReady(tx_ready),
    .o_router(router_out), .o_routerValid(router_valid), .i_routerReady(router_ready_in),
    .i_router(router_in), .i_routerValid(router_valid_in), .o_routerReady(router_ready),
    .o_rxPayload(rx_payload), .o_rxSrcRow(rx_src_row), .o_rxSrcCol(rx_src_col),
    .o_rxValid(rx_valid), .i_rxReady(rx_ready),
    .o_txCount(tx_count), .o_rxCount(rx_count), .o_misroute(misroute)
  );

  network_interface #(.GRID_WIDTH(4), .NI_ROW(ROW), .NI_COL(COL), .CNT_WIDTH(2)) dut_sat (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_txPayload(tx_payload), .i_txDstRow(tx_dst_row), .i_txDstCol(tx_dst_col),
    .i_txValid(tx_valid), .o_txReady(tx_ready2),
    .o_router(router_out2), .o_routerValid(router_valid2), .i_routerReady(router_ready_in),
    .i_router(router_in), .i_routerValid(router_valid_in), .o_routerReady(router_ready2),
    .o_rxPayload(rx_payload2), .o_rxSrcRow(rx_src_row2), .o_rxSrcCol(rx_src_col2),
    .o_rxValid(rx_valid2), .i_rxReady(rx_ready),
    .o_txCount(tx_count2), .o_rxCount(rx_count2), .o_misroute(misroute2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int pay, input int dr, input int dc);
    return 16'((pay << 8) | (ROW << 6) | (COL << 4) | (dr << 2) | dc);
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_outputs();
    chk("router_valid", 32'(router_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("router_pkt", 32'(router_out), 32'(txq[0]));
    chk("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
    if (rxq.size() != 0) begin
      chk("rx_payload", 32'(rx_payload), 32'(rxq[0] >> 8));
      chk("rx_src_row", 32'(rx_src_row), 32'((rxq[0] >> 6) & 3));
      chk("rx_src_col", 32'(rx_src_col), 32'((rxq[0] >> 4) & 3));
    end
    chk("tx_count", 32'(tx_count), 32'(sat(m_tx_cnt, 65535)));
    chk("rx_count", 32'(rx_count), 32'(sat(m_rx_cnt, 65535)));
    chk("tx_count_sat2", 32'(tx_count2), 32'(sat(m_tx_cnt, 3)));
    chk("rx_count_sat2", 32'(rx_count2), 32'(sat(m_rx_cnt, 3)));
    chk("misroute", 32'(misroute), 32'(m_misroute));
  endtask

  // Applies the currently driven inputs for one clock and advances the reference model.
  task automatic cycle();
    bit tx_xfer, tx_acc, rx_cons, rx_acc;
    #1;
    chk("tx_ready", 32'(tx_ready), 32'((txq.size() == 0) || router_ready_in));
    chk("router_ready", 32'(router_ready), 32'((rxq.size() == 0) || rx_ready));
    tx_xfer = (txq.size() != 0) && router_ready_in;
    tx_acc  = tx_valid && ((txq.size() == 0) || router_ready_in);
    rx_cons = (rxq.size() != 0) && rx_ready;
    rx_acc  = router_valid_in && ((rxq.size() == 0) || rx_ready);
    if (tx_xfer) begin
      void'(txq.pop_front());
      m_tx_cnt++;
    end
    if (tx_acc) txq.push_back(pack(int'(tx_payload), int'(tx_dst_row), int'(tx_dst_col)));
    if (rx_cons) begin
      void'(rxq.pop_front());
      m_rx_cnt++;
    end
    if (rx_acc) begin
      if (int'((router_in >> 2) & 3) == ROW && int'(router_in & 3) == COL) rxq.push_back(router_in);
      else m_misroute = 1'b1;
    end
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int dr, dc;
    i_arst_n = 1'b0;
    tx_payload = '0; tx_dst_row = '0; tx_dst_col = '0; tx_valid = 1'b0;
    router_ready_in = 1'b0; router_in = '0; router_valid_in = 1'b0; rx_ready = 1'b0;
    m_tx_cnt = 0; m_rx_cnt = 0; m_misroute = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_arst_n = 1'b1;

    chk("reset_router_valid", 32'(router_valid), 32'h0);
    chk("reset_router", 32'(router_out), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_tx_count", 32'(tx_count), 32'h0);
    chk("reset_misroute", 32'(misroute), 32'h0);
    chk("reset_tx_ready", 32'(tx_ready), 32'h1);
    chk("reset_router_ready", 32'(router_ready), 32'h1);

    // single send to (3,0)
    router_ready_in = 1'b1;
    tx_payload = 8'hA5; tx_dst_row = 2'd3; tx_dst_col = 2'd0; tx_valid = 1'b1;
    cycle();
    chk("single_pkt", 32'(router_out), 32'h0000A56C);
    tx_valid = 1'b0;
    cycle();
    chk("single_valid_drop", 32'(router_valid), 32'h0);
    chk("single_count", 32'(tx_count), 32'h1);
    cycle();

    // backpressure with a second request held at the core
    router_ready_in = 1'b0;
    tx_payload = 8'h11; tx_dst_row = 2'd0; tx_dst_col = 2'd1; tx_valid = 1'b1;
    cycle();
    tx_payload = 8'h22; tx_dst_row = 2'd2; tx_dst_col = 2'd3;
    repeat (5) cycle();
    chk("bp_held_pkt", 32'(router_out), 32'(pack(8'h11, 0, 1)));
    router_ready_in = 1'b1;
    cycle();
    tx_valid = 1'b0;
    cycle();
    chk("bp_count", 32'(tx_count), 32'h3);
    cycle();

    // receive with the core stalled
    rx_ready = 1'b0;
    router_in = 16'h3C06; router_valid_in = 1'b1;
    cycle();
    router_valid_in = 1'b0;
    chk("rx_payload_3c", 32'(rx_payload), 32'h3C);
    repeat (2) cycle();
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;

    // misroute to (2,2)
    router_in = 16'h550A; router_valid_in = 1'b1;
    cycle();
    router_valid_in = 1'b0;
    repeat (2) cycle();
    chk("misroute_sticky", 32'(misroute), 32'h1);
    chk("misroute_no_rx", 32'(rx_valid), 32'h0);

    // five back-to-back sends saturate the 2-bit counter
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_payload = 8'(i + 8'h40);
      cycle();
    end
    tx_valid = 1'b0;
    cycle();
    chk("tx_count2_saturated", 32'(tx_count2), 32'h3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_payload = 8'($urandom);
      tx_dst_row = 2'($urandom);
      tx_dst_col = 2'($urandom);
      router_ready_in = ($urandom_range(0, 3) != 0);
      router_valid_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        dr = ROW; dc = COL;
      end else begin
        dr = int'($urandom_range(0, 3)); dc = int'($urandom_range(0, 3));
      end
      router_in = 16'(($urandom & 32'hFFF0) | 32'(dr << 2) | 32'(dc));
      rx_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // asynchronous reset with both registers occupied
    router_ready_in = 1'b0; rx_ready = 1'b0;
    tx_valid = 1'b1; tx_payload = 8'h77; tx_dst_row = 2'd1; tx_dst_col = 2'd1;
    router_in = 16'h9906; router_valid_in = 1'b1;
    cycle();
    tx_valid = 1'b0; router_valid_in = 1'b0;
    chk("pre_reset_tx_full", 32'(router_valid), 32'h1);
    chk("pre_reset_rx_valid", 32'(rx_valid), 32'h1);
    #2 i_arst_n = 1'b0;
    #1;
    chk("arst_router_valid", 32'(router_valid), 32'h0);
    chk("arst_router", 32'(router_out), 32'h0);
    chk("arst_rx_valid", 32'(rx_valid), 32'h0);
    chk("arst_rx_payload", 32'(rx_payload), 32'h0);
    chk("arst_rx_src", 32'({rx_src_row, rx_src_col}), 32'h0);
    chk("arst_tx_count", 32'(tx_count), 32'h0);
    chk("arst_rx_count", 32'(rx_count), 32'h0);
    chk("arst_misroute", 32'(misroute), 32'h0);
    txq.delete(); rxq.delete();
    m_tx_cnt = 0; m_rx_cnt = 0; m_misroute = 1'b0;
    @(posedge i_clk);
    #1 i_arst_n = 1'b1;
    #1;
    chk("post_reset_tx_ready", 32'(tx_ready), 32'h1);
    chk("post_reset_router_ready", 32'(router_ready), 32'h1);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
